// File: rtl/fp_pkg.sv
// Shared constants for the FPU schedulers: FSM encoding, default NaN and
// IEEE-754 single-precision field positions.
package fp_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin pick: the first set request at or after ptr_i,
// wrapping modulo NUM_REQ, wins.
module rr_arbiter_comb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_gnt_o
);

  // Scan from lowest to highest priority so the last hit is the winner.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0]   pick;
    logic [IDX_W-1:0] cand;
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        pick = {1'b1, cand};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Winner index and its one-hot form
  always_comb begin
    {any_gnt_o, gnt_idx_o} = rr_pick(req_i, ptr_i);
    gnt_o = any_gnt_o ? (NUM_REQ'(1) << gnt_idx_o) : '0;
  end

endmodule

// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler sharing one multi-cycle fp_add_sub unit between
// NUM_REQ requesters; one operation in flight, result routed back to its owner.
module fp_addsub_sched
  import fp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  input  logic [NUM_REQ-1:0]      req_sub,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    fu_start,
  output logic                    fu_s_a,
  output logic [7:0]              fu_e_a,
  output logic [22:0]             fu_f_a,
  output logic                    fu_s_b,
  output logic [7:0]              fu_e_b,
  output logic [22:0]             fu_f_b,
  output logic                    fu_op_is_sub,
  input  logic [31:0]             fu_result,
  input  logic                    fu_done,
  output logic                    busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fu_start_q, fu_start_d, op_q, op_d, err_q, err_d;
  logic [31:0]        opa_q, opa_d, opb_q, opb_d, data_q, data_d;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any, timeout_hit;
  logic [31:0]        a_sel, b_sel;

  rr_arbiter_comb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (arb_gnt),
    .gnt_idx_o(arb_idx),
    .any_gnt_o(arb_any)
  );

  assign a_sel       = req_a[32*int'(arb_idx) +: 32];
  assign b_sel       = req_b[32*int'(arb_idx) +: 32];
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; fu_done outside ISSUE is a stale pulse and is ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = arb_any ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_d = (fu_done || timeout_hit) ? ST_RESP : ST_ISSUE;
      ST_RESP:  state_d = rsp_ready[owner_q] ? ST_GAP : ST_RESP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; req_ready is forced low while reset is held
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE:  req_ready = rst_n ? arb_gnt : '0;
      ST_ISSUE: busy = 1'b1;
      ST_RESP: begin
        rsp_valid = NUM_REQ'(1) << owner_q;
        busy      = 1'b1;
      end
      ST_GAP:   busy = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  // Datapath next values: capture on grant, finish on done (wins) or timeout
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    fu_start_d = 1'b0;
    opa_d      = opa_q;
    opb_d      = opb_q;
    op_d       = op_q;
    data_d     = data_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          owner_d    = arb_idx;
          rr_ptr_d   = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IDX_W'(1);
          opa_d      = a_sel;
          opb_d      = b_sel;
          op_d       = req_sub[arb_idx];
          cnt_d      = '0;
          fu_start_d = 1'b1;
        end else begin
          fu_start_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fu_done) begin
          data_d     = fu_result;
          err_d      = 1'b0;
          fu_start_d = 1'b0;
        end else if (timeout_hit) begin
          data_d     = QNAN_DEFAULT;
          err_d      = 1'b1;
          fu_start_d = 1'b0;
        end else begin
          fu_start_d = 1'b1;
        end
      end
      default: fu_start_d = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      fu_start_q <= 1'b0;
      opa_q      <= 32'h0000_0000;
      opb_q      <= 32'h0000_0000;
      op_q       <= 1'b0;
      data_q     <= 32'h0000_0000;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      fu_start_q <= fu_start_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      op_q       <= op_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign fu_start     = fu_start_q;
  assign fu_s_a       = opa_q[SIGN_BIT];
  assign fu_e_a       = opa_q[EXP_MSB:EXP_LSB];
  assign fu_f_a       = opa_q[FRAC_MSB:0];
  assign fu_s_b       = opb_q[SIGN_BIT];
  assign fu_e_b       = opb_q[EXP_MSB:EXP_LSB];
  assign fu_f_b       = opb_q[FRAC_MSB:0];
  assign fu_op_is_sub = op_q;
  assign rsp_data     = data_q;
  assign rsp_err      = err_q;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed bench for fp_addsub_sched with a latency-programmable stub adder.
module tb_fp_addsub_sched;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
  logic [N*32-1:0]  req_a, req_b;
  logic [31:0]      rsp_data, fu_result;
  logic             rsp_err, fu_start, fu_s_a, fu_s_b, fu_op_is_sub, fu_done, busy;
  logic [7:0]       fu_e_a, fu_e_b;
  logic [22:0]      fu_f_a, fu_f_b;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          stub_lat;
  bit          stub_en;
  bit          force_done;
  logic [31:0] stub_res;
  int          start_cnt;

  always #5 clk = ~clk;

  fp_addsub_sched #(.NUM_REQ(N), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .fu_start(fu_start),
    .fu_s_a(fu_s_a), .fu_e_a(fu_e_a), .fu_f_a(fu_f_a),
    .fu_s_b(fu_s_b), .fu_e_b(fu_e_b), .fu_f_b(fu_f_b),
    .fu_op_is_sub(fu_op_is_sub),
    .fu_result(fu_result), .fu_done(fu_done),
    .busy(busy)
  );

  // Stub unit: done after fu_start has been high stub_lat cycles, held until start drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_cnt <= 0;
    else        start_cnt <= fu_start ? start_cnt + 1 : 0;
  end
  assign fu_done   = force_done | (stub_en & fu_start & (start_cnt >= stub_lat));
  assign fu_result = stub_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs();
    check("rst_ctl", 32'({req_ready, rsp_valid, rsp_err, fu_start, busy, fu_op_is_sub, fu_s_a, fu_s_b}), 32'h0);
    check("rst_data", rsp_data, 32'h0);
    check("rst_fa", 32'({fu_e_a, fu_f_a}), 32'h0);
    check("rst_fb", 32'({fu_e_b, fu_f_b}), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Wait for the grant, then for the response; cycle counts are relative to the grant
  task automatic do_op(input int exp_idx, input bit keep, output int g_cyc, output int r_cyc, output int hi);
    logic [N-1:0] gv;
    gv    = '0;
    g_cyc = -1;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (req_ready != '0) begin
        gv    = req_ready;
        g_cyc = k;
        break;
      end
      @(posedge clk);
    end
    check("grant_vec", 32'(gv), 32'(1) << exp_idx);
    @(posedge clk); #1;
    if (!keep) req_valid[exp_idx] = 1'b0;
    hi    = 0;
    r_cyc = -1;
    for (int k = 1; k < 300; k++) begin
      if (fu_start) hi++;
      if (rsp_valid != '0) begin
        r_cyc = k;
        break;
      end
      @(posedge clk); #1;
    end
    check("rsp_owner", 32'(rsp_valid), 32'(1) << exp_idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    int g, r, h;
    int order [5] = '{0, 1, 2, 3, 2};
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0;
    rsp_ready = '1; stub_en = 1'b1; stub_lat = 7; force_done = 1'b0; stub_res = 32'h0;
    #3;
    chk_reset_outs();
    @(posedge clk); #3 rst_n = 1'b1;

    // 1: single request, 1.0 + 2.0
    req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h4000_0000; req_sub[0] = 1'b0;
    stub_res = 32'h4040_0000; req_valid[0] = 1'b1;
    do_op(0, 1'b0, g, r, h);
    check("t1_grant_lat", 32'(g), 32'd0);
    check("t1_rsp_lat", 32'(r), 32'd9);
    check("t1_start_hi", 32'(h), 32'd8);
    check("t1_data", rsp_data, 32'h4040_0000);
    check("t1_err", 32'(rsp_err), 32'h0);
    check("t1_fa", {fu_s_a, fu_e_a, fu_f_a}, 32'h3F80_0000);
    check("t1_fb", {fu_s_b, fu_e_b, fu_f_b}, 32'h4000_0000);
    check("t1_sub", 32'(fu_op_is_sub), 32'h0);

    // 2: all requesters valid, round-robin order, req 2 held for a second turn
    do_reset();
    stub_lat = 2;
    for (int k = 0; k < N; k++) begin
      req_a[32*k +: 32] = {1'b0, 8'(k + 1), 23'(k)};
      req_b[32*k +: 32] = 32'h3F80_0000;
      req_sub[k] = (k % 2) == 1;
    end
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      stub_res = 32'hC000_0000 + 32'(i);
      do_op(order[i], i == 2, g, r, h);
      check("t2_grant_gap", 32'(g), (i == 0) ? 32'd0 : 32'd2);
      check("t2_data", rsp_data, 32'hC000_0000 + 32'(i));
      check("t2_ea", 32'(fu_e_a), 32'(order[i] + 1));
      check("t2_sub", 32'(fu_op_is_sub), 32'(order[i] % 2));
    end

    // 3: stalled response on requester 1; other rsp_ready bits ignored
    rsp_ready = 4'b1101; stub_res = 32'h1234_5678; req_valid[1] = 1'b1;
    do_op(1, 1'b0, g, r, h);
    check("t3_data", rsp_data, 32'h1234_5678);
    req_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t3_hold_valid", 32'(rsp_valid), 32'h2);
      check("t3_hold_data", rsp_data, 32'h1234_5678);
      check("t3_no_grant", 32'(req_ready), 32'h0);
      check("t3_start_low", 32'(fu_start), 32'h0);
    end
    rsp_ready = '1; stub_res = 32'h0BAD_F00D;
    do_op(0, 1'b0, g, r, h);
    check("t3_release_gap", 32'(g), 32'd2);
    check("t3_next_data", rsp_data, 32'h0BAD_F00D);

    // 4: timeout abort, then a normal operation
    stub_en = 1'b0; req_valid[1] = 1'b1;
    do_op(1, 1'b0, g, r, h);
    check("t4_rsp_lat", 32'(r), 32'd65);
    check("t4_start_hi", 32'(h), 32'd64);
    check("t4_err", 32'(rsp_err), 32'h1);
    check("t4_data", rsp_data, 32'h7FC0_0000);
    stub_en = 1'b1; stub_lat = 3; stub_res = 32'h3F00_0000; req_valid[2] = 1'b1;
    do_op(2, 1'b0, g, r, h);
    check("t4_next_lat", 32'(r), 32'd5);
    check("t4_next_err", 32'(rsp_err), 32'h0);
    check("t4_next_data", rsp_data, 32'h3F00_0000);

    // 5: done on the timeout cycle wins; spurious done in IDLE ignored
    stub_lat = 63; stub_res = 32'h4120_0000; req_valid[3] = 1'b1;
    do_op(3, 1'b0, g, r, h);
    check("t5_rsp_lat", 32'(r), 32'd65);
    check("t5_err", 32'(rsp_err), 32'h0);
    check("t5_data", rsp_data, 32'h4120_0000);
    repeat (3) begin
      @(posedge clk); #1;
    end
    force_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t5_spur_rsp", 32'(rsp_valid), 32'h0);
      check("t5_spur_busy", 32'(busy), 32'h0);
    end
    force_done = 1'b0;

    // 6: reset mid-ISSUE, then pending req 3 and pointer wrap
    stub_lat = 20; req_a[63:32] = 32'hC0A0_0000; req_valid = 4'b0010;
    #1;
    check("t6_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = 4'b1000;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("t6_issue", 32'(fu_start), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs();
    @(posedge clk); #3 rst_n = 1'b1;
    stub_lat = 2; stub_res = 32'h5555_AAAA;
    do_op(3, 1'b0, g, r, h);
    check("t6_post_grant", 32'(g), 32'd0);
    check("t6_post_data", rsp_data, 32'h5555_AAAA);
    req_valid = 4'b1001;
    do_op(0, 1'b0, g, r, h);
    check("t6_wrap_gap", 32'(g), 32'd2);
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
